traffic_sequencer: RTL
======================

// Module: traffic_sequencer
// PURPOSE
//  Master FSM for the junction: sequences main/side signal heads and drives the
//  Timer (start_timer + 4-bit interval load), advancing on its one-cycle expired pulse.
//  Holds a small programmable interval register file. Latches the side-road vehicle sensor
//  (and, when the PED_WALK_EN macro is defined, a pedestrian request).
// PARAMETERS
//  T_BASE  6  default base-green interval (s), 4-bit
//  T_EXT   3  default extension / walk interval (s), 4-bit
//  T_YEL   2  default yellow interval (s), 4-bit
// PORTS
//  clk            in   1  system clock
//  reset_global   in   1  asynchronous, active-low reset
//  sensor         in   1  side-road vehicle present (synchronous to clk)
//  walk_req       in   1  pedestrian button; used only with PED_WALK_EN
//  prog_strobe    in   1  write interval register this cycle
//  prog_sel       in   2  0=BASE 1=EXT 2=YEL 3=ignored
//  prog_value     in   4  interval to write
//  expired        in   1  Timer expiry pulse
//  start_timer    out  1  one-cycle load pulse to Timer
//  time_value     out  4  interval presented with start_timer
//  main_light     out  3  {R,Y,G} main road
//  side_light     out  3  {R,Y,G} side road
//  walk_light     out  1  pedestrian walk lamp
// BEHAVIOUR
//  - All outputs registered. Reset: state=M_GRN, start_timer=0, time_value=0,
//    main_light=001, side_light=100, walk_light=0, side_req=0, walk_pend=0, regs=defaults.
//  - First edge after reset release: start_timer=1, time_value=BASE (state M_GRN).
//  - Every state entry: start_timer=1 for exactly one cycle, time_value=interval of new state;
//    state, lights and load pulse all update on the same edge expired is sampled high.
//  - States / lights (main,side) / interval / exit on expired:
//    M_GRN  (001,100) BASE: side_req|sensor -> M_YEL, else -> M_IDLE
//    M_IDLE (001,100) no timer load; leaves on the first cycle side_req|sensor=1 -> M_YEL
//    M_YEL  (010,100) YEL : -> S_GRN; side_req cleared on entry to S_GRN
//    S_GRN  (100,001) BASE: sensor=1 -> S_EXT, else -> S_YEL
//    S_EXT  (100,001) EXT : -> S_YEL (single extension only)
//    S_YEL  (100,010) YEL : walk_pend -> WALK, else -> M_GRN
//    WALK   (100,100) EXT : walk_light=1 for the whole state; -> M_GRN; walk_pend cleared on entry
//  - side_req: set by sensor=1 in any main-green/yellow state; cleared only on S_GRN entry.
//  - expired seen while start_timer is high, or in M_IDLE: ignored.
//  - Interval regs: a write of 0 stores 1 (Timer cannot count 0).
//    The write is visible on the next load only; an in-flight interval is unaffected.
//    A write and a load on the same edge: the load uses the old value.
//  - Reset asserted mid-sequence: immediate return to reset values; programmed intervals lost.
//  - Illegal state encoding -> M_GRN with load of BASE.
// CONFIGURATION
//  PED_WALK_EN defined: walk_req sets walk_pend (sticky) in any state except WALK;
//    WALK state reachable as above.
//  PED_WALK_EN undefined: WALK state absent, walk_req ignored, walk_light tied 0,
//    S_YEL always -> M_GRN.
// TESTING
//  1 Release reset -> next edge start_timer=1, time_value=6, main=001, side=100.
//  2 sensor=0, BASE expires -> M_IDLE, no start_timer.
//    Pulse sensor 1 cycle -> M_YEL, time_value=2.
//  3 Full cycle, sensor held 1 -> M_GRN(6)->M_YEL(2)->S_GRN(6)->S_EXT(3)->S_YEL(2)->M_GRN(6).
//    Loads in that order, one start_timer each.
//  4 prog_strobe sel=2 val=0 during S_GRN -> next S_YEL loads 1.
//    Write on the same edge as a YEL load -> that load still uses the old value.
//  5 PED_WALK_EN: walk_req pulse in M_GRN, full cycle -> after S_YEL: WALK, walk_light=1,
//    both heads 100, load 3.
//    Without the macro: S_YEL -> M_GRN and walk_light stays 0.
//  6 Assert reset during S_EXT -> outputs at reset values asynchronously, before the next
//    clk edge; regs back to 6/3/2.

Source files
------------

// File: rtl/traffic_sequencer.sv
// Junction master sequencer: drives the main/side signal heads and loads the external interval
// timer. The pedestrian walk phase is compiled in only when PED_WALK_EN is defined.
module traffic_sequencer #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       reset_global,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       prog_strobe,
  input  logic [1:0] prog_sel,
  input  logic [3:0] prog_value,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] time_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light
);

  localparam logic [2:0] StMGrn  = 3'd0;
  localparam logic [2:0] StMIdle = 3'd1;
  localparam logic [2:0] StMYel  = 3'd2;
  localparam logic [2:0] StSGrn  = 3'd3;
  localparam logic [2:0] StSExt  = 3'd4;
  localparam logic [2:0] StSYel  = 3'd5;
`ifdef PED_WALK_EN
  localparam logic [2:0] StWalk  = 3'd6;
`endif

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  // The timer cannot count a zero interval, so zero is stored as one.
  localparam logic [3:0] BaseInit = (T_BASE == 4'd0) ? 4'd1 : T_BASE;
  localparam logic [3:0] ExtInit  = (T_EXT  == 4'd0) ? 4'd1 : T_EXT;
  localparam logic [3:0] YelInit  = (T_YEL  == 4'd0) ? 4'd1 : T_YEL;

  logic [2:0] state_q, state_d;
  logic       boot_q;
  logic       load;
  logic       advance;
  logic       want_side;
  logic       main_phase;
  logic       side_req_q, side_req_d;
  logic [3:0] base_q, base_d;
  logic [3:0] ext_q, ext_d;
  logic [3:0] yel_q, yel_d;
  logic [3:0] interval;
  logic [3:0] prog_clamped;
  logic [3:0] time_value_d;
  logic [2:0] main_d, side_d;

`ifdef PED_WALK_EN
  logic walk_pend_q, walk_pend_d;
`endif

  // Expiry is only meaningful once the load pulse of the current state has gone.
  assign advance    = expired & ~start_timer;
  assign want_side  = side_req_q | sensor;
  assign main_phase = (state_q == StMGrn) || (state_q == StMIdle) || (state_q == StMYel);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (!boot_q) begin
      state_d = StMGrn;
      load    = 1'b1;
    end else begin
      case (state_q)
        StMGrn: begin
          if (advance) begin
            if (want_side) begin
              state_d = StMYel;
              load    = 1'b1;
            end else begin
              state_d = StMIdle;
            end
          end
        end
        StMIdle: begin
          if (want_side) begin
            state_d = StMYel;
            load    = 1'b1;
          end
        end
        StMYel: begin
          if (advance) begin
            state_d = StSGrn;
            load    = 1'b1;
          end
        end
        StSGrn: begin
          if (advance) begin
            state_d = sensor ? StSExt : StSYel;
            load    = 1'b1;
          end
        end
        StSExt: begin
          if (advance) begin
            state_d = StSYel;
            load    = 1'b1;
          end
        end
        StSYel: begin
          if (advance) begin
`ifdef PED_WALK_EN
            state_d = walk_pend_q ? StWalk : StMGrn;
`else
            state_d = StMGrn;
`endif
            load    = 1'b1;
          end
        end
`ifdef PED_WALK_EN
        StWalk: begin
          if (advance) begin
            state_d = StMGrn;
            load    = 1'b1;
          end
        end
`endif
        default: begin
          state_d = StMGrn;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Interval of the state being entered; reads the registers before any same-edge write.
  always_comb begin
    case (state_d)
      StMGrn, StSGrn: interval = base_q;
      StMYel, StSYel: interval = yel_q;
      default:        interval = ext_q;
    endcase
    time_value_d = load ? interval : time_value;
  end

  always_comb begin
    main_d = LampRed;
    side_d = LampRed;
    case (state_d)
      StMGrn, StMIdle: main_d = LampGrn;
      StMYel:          main_d = LampYel;
      StSGrn, StSExt:  side_d = LampGrn;
      StSYel:          side_d = LampYel;
      default: ;
    endcase
  end

  always_comb begin
    side_req_d = side_req_q;
    if (load && (state_d == StSGrn)) begin
      side_req_d = 1'b0;
    end else if (sensor && main_phase) begin
      side_req_d = 1'b1;
    end
  end

  assign prog_clamped = (prog_value == 4'd0) ? 4'd1 : prog_value;

  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (prog_strobe) begin
      case (prog_sel)
        2'd0:    base_d = prog_clamped;
        2'd1:    ext_d  = prog_clamped;
        2'd2:    yel_d  = prog_clamped;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_global) begin
    if (!reset_global) begin
      state_q     <= StMGrn;
      boot_q      <= 1'b0;
      side_req_q  <= 1'b0;
      base_q      <= BaseInit;
      ext_q       <= ExtInit;
      yel_q       <= YelInit;
      start_timer <= 1'b0;
      time_value  <= 4'd0;
      main_light  <= LampGrn;
      side_light  <= LampRed;
    end else begin
      state_q     <= state_d;
      boot_q      <= 1'b1;
      side_req_q  <= side_req_d;
      base_q      <= base_d;
      ext_q       <= ext_d;
      yel_q       <= yel_d;
      start_timer <= load;
      time_value  <= time_value_d;
      main_light  <= main_d;
      side_light  <= side_d;
    end
  end

`ifdef PED_WALK_EN
  always_comb begin
    walk_pend_d = walk_pend_q;
    if (load && (state_d == StWalk)) begin
      walk_pend_d = 1'b0;
    end else if (walk_req && (state_q != StWalk)) begin
      walk_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_global) begin
    if (!reset_global) begin
      walk_pend_q <= 1'b0;
      walk_light  <= 1'b0;
    end else begin
      walk_pend_q <= walk_pend_d;
      walk_light  <= (state_d == StWalk);
    end
  end
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign walk_light      = 1'b0;
`endif

endmodule
